if_fetch_unit: RTL and testbench

//   Instruction-fetch stage of the MIPS 32-bit pipeline; sits directly upstream of the IF/ID register.

---
 rtl/if_fetch_unit.sv | 124 ++++++++++++
 tb/tb_if_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS instruction-fetch stage. Owns the PC, keeps one imem request in flight,
// and feeds {instruction, PC+4, valid} to IF/ID while absorbing stalls and branch/jump redirects.
`default_nettype none

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_in,
   input  logic        enable,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] Jump_Offset_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_out,
   output logic [31:0] PC_Counter_out,
   output logic        if_valid,
   output logic        IF_ID_flush
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_instr;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_next;

   // Branch has priority; the jump region comes from the PC+4 of the jump sitting in ID.
   assign redirect = branch_taken | jump;
   assign target   = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                  : {PC_Counter_out[31:28], Jump_Offset_in, 2'b00};
   assign pc_next  = pc + 32'd4;

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state           <= ST_IDLE;
         pc              <= RESET_PC;
         hold_instr      <= NOP_INSTR;
         imem_req        <= 1'b0;
         imem_addr       <= RESET_PC;
         Instruction_out <= NOP_INSTR;
         PC_Counter_out  <= 32'h0000_0000;
         if_valid        <= 1'b0;
         IF_ID_flush     <= 1'b0;
      end else begin
         imem_req    <= 1'b0;
         IF_ID_flush <= 1'b0;
         if (redirect) begin
            pc              <= target;
            IF_ID_flush     <= 1'b1;
            if_valid        <= 1'b0;
            Instruction_out <= NOP_INSTR;
            // A request still in flight must drain before the target can be fetched.
            if ((state == ST_WAIT || state == ST_DROP) && !imem_rvalid) begin
               state <= ST_DROP;
            end else begin
               imem_req  <= 1'b1;
               imem_addr <= target;
               state     <= ST_WAIT;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
                  state     <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (imem_rvalid) begin
                     if (enable) begin
                        Instruction_out <= imem_rdata;
                        PC_Counter_out  <= pc_next;
                        if_valid        <= 1'b1;
                        pc              <= pc_next;
                        imem_req        <= 1'b1;
                        imem_addr       <= pc_next;
                     end else begin
                        hold_instr <= imem_rdata;
                        state      <= ST_HOLD;
                     end
                  end else if (enable) begin
                     if_valid        <= 1'b0;
                     Instruction_out <= NOP_INSTR;
                  end
               end
               ST_HOLD: begin
                  if (enable) begin
                     Instruction_out <= hold_instr;
                     PC_Counter_out  <= pc_next;
                     if_valid        <= 1'b1;
                     pc              <= pc_next;
                     imem_req        <= 1'b1;
                     imem_addr       <= pc_next;
                     state           <= ST_WAIT;
                  end
               end
               ST_DROP: begin
                  if (imem_rvalid) begin
                     imem_req  <= 1'b1;
                     imem_addr <= pc;
                     state     <= ST_WAIT;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus for if_fetch_unit with a bench-side instruction memory
// and a stream-level model checked every cycle.
`default_nettype none

module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_in = 1'b0;
   logic        enable = 1'b1;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] Jump_Offset_in = 26'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] Instruction_out;
   logic [31:0] PC_Counter_out;
   logic        if_valid;
   logic        IF_ID_flush;

   int total = 0;
   int bad   = 0;
   int mem_lat = 1;

   // inputs as seen by the DUT at the last rising edge
   logic        s_rst = 1'b0, s_en = 1'b0, s_br = 1'b0, s_jmp = 1'b0;
   logic [31:0] s_bt = 32'h0;
   logic [25:0] s_off = 26'h0;

   // stream model: address of the next instruction to be delivered
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] last_pcp4 = 32'h0;
   logic [31:0] prev_instr = 32'h0, prev_pcout = 32'h0;
   logic        prev_valid = 1'b0;

   // memory model
   bit          pend = 1'b0, stray = 1'b0;
   int          cnt = 0;
   logic [31:0] req_addr = 32'h0;

   if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .reset_in       (reset_in),
      .enable         (enable),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .Jump_Offset_in (Jump_Offset_in),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .Instruction_out(Instruction_out),
      .PC_Counter_out (PC_Counter_out),
      .if_valid       (if_valid),
      .IF_ID_flush    (IF_ID_flush)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h8210_0000 : (a ^ 32'h1357_9BDF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, expv);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 20 && !if_valid; i++) tick();
      chk1(name, if_valid, 1'b1);
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 20 && !imem_req; i++) tick();
      chk1(name, imem_req, 1'b1);
   endtask

   always @(posedge clk) begin
      s_rst = reset_in;
      s_en  = enable;
      s_br  = branch_taken;
      s_jmp = jump;
      s_bt  = branch_target;
      s_off = Jump_Offset_in;
   end

   // Per-cycle compare against the stream model, then the memory responds.
   always @(negedge clk) begin
      if (!reset_in || !s_rst) begin
         chk1("rst_valid", if_valid, 1'b0);
         chk1("rst_flush", IF_ID_flush, 1'b0);
         chk1("rst_req", imem_req, 1'b0);
         chk("rst_addr", imem_addr, RST_PC);
         chk("rst_instr", Instruction_out, NOP);
         chk("rst_pcout", PC_Counter_out, 32'h0);
         exp_pc    = RST_PC;
         last_pcp4 = 32'h0;
      end else begin
         if (s_br || s_jmp) begin
            exp_pc = s_br ? {s_bt[31:2], 2'b00} : {last_pcp4[31:28], s_off, 2'b00};
            chk1("mdl_flush", IF_ID_flush, 1'b1);
            chk1("mdl_redir_valid", if_valid, 1'b0);
            chk("mdl_redir_instr", Instruction_out, NOP);
         end else begin
            chk1("mdl_noflush", IF_ID_flush, 1'b0);
            if (!s_en) begin
               chk("mdl_hold_instr", Instruction_out, prev_instr);
               chk("mdl_hold_pcout", PC_Counter_out, prev_pcout);
               chk1("mdl_hold_valid", if_valid, prev_valid);
            end else if (if_valid) begin
               chk("mdl_instr", Instruction_out, mem_word(exp_pc));
               chk("mdl_pcout", PC_Counter_out, exp_pc + 32'd4);
               exp_pc    = exp_pc + 32'd4;
               last_pcp4 = exp_pc;
            end else begin
               chk("mdl_bubble", Instruction_out, NOP);
            end
         end
         if (imem_req) begin
            chk("mdl_req_addr", imem_addr, exp_pc);
            chk1("mdl_one_outstanding", pend && !stray, 1'b0);
         end else if (pend && !stray) begin
            chk("mdl_addr_stable", imem_addr, req_addr);
         end
      end
      prev_instr = Instruction_out;
      prev_pcout = PC_Counter_out;
      prev_valid = if_valid;

      imem_rvalid = 1'b0;
      if (imem_req && reset_in) begin
         pend     = 1'b1;
         stray    = 1'b0;
         req_addr = imem_addr;
         cnt      = mem_lat - 1;
      end
      if (!reset_in && pend) stray = 1'b1;
      if (pend) begin
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = stray ? 32'hDEAD_BEEF : mem_word(req_addr);
            pend        = 1'b0;
         end else begin
            cnt--;
         end
      end
   end

   initial begin
      // reset release and first fetch, 1-cycle memory
      repeat (2) tick();
      reset_in = 1'b1;
      tick();
      chk1("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'h0);
      chk1("t1_valid0", if_valid, 1'b0);
      tick();
      chk("t1_instr", Instruction_out, 32'h8210_0000);
      chk("t1_pcout", PC_Counter_out, 32'h4);
      chk1("t1_valid", if_valid, 1'b1);
      chk1("t1_nreq", imem_req, 1'b1);
      chk("t1_naddr", imem_addr, 32'h4);

      // stall for 3 cycles while the response to 0x4 arrives
      enable = 1'b0;
      repeat (3) begin
         tick();
         chk1("t2_noreq", imem_req, 1'b0);
         chk("t2_instr", Instruction_out, 32'h8210_0000);
         chk("t2_pcout", PC_Counter_out, 32'h4);
      end
      enable = 1'b1;
      tick();
      chk("t2_instr_rel", Instruction_out, 32'h1357_9BDB);
      chk("t2_pcout_rel", PC_Counter_out, 32'h8);
      chk1("t2_valid_rel", if_valid, 1'b1);
      chk("t2_naddr", imem_addr, 32'h8);

      // branch while the request for 0x8 is still in flight
      mem_lat       = 3;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0103;
      tick();
      branch_taken = 1'b0;
      chk1("t3_flush", IF_ID_flush, 1'b1);
      chk1("t3_valid", if_valid, 1'b0);
      chk("t3_instr", Instruction_out, NOP);
      tick();
      chk1("t3_flush_once", IF_ID_flush, 1'b0);
      chk1("t3_noreq_drop", imem_req, 1'b0);
      wait_req("t3_req_seen");
      chk("t3_req_addr", imem_addr, 32'h100);
      wait_valid("t3_valid_seen");
      chk("t3_word", Instruction_out, 32'h1357_9ADF);
      chk("t3_pcout", PC_Counter_out, 32'h104);

      // jump with PC_Counter_out = 0xA000_0010
      mem_lat       = 1;
      branch_taken  = 1'b1;
      branch_target = 32'hA000_000C;
      tick();
      branch_taken = 1'b0;
      wait_valid("t4_valid_seen");
      chk("t4_word", Instruction_out, 32'hB357_9BD3);
      chk("t4_pcout", PC_Counter_out, 32'hA000_0010);
      enable         = 1'b0;
      jump           = 1'b1;
      Jump_Offset_in = 26'h000_0040;
      tick();
      jump = 1'b0;
      chk1("t4_flush", IF_ID_flush, 1'b1);
      wait_req("t4_req_seen");
      chk("t4_jaddr", imem_addr, 32'hA000_0100);
      enable         = 1'b1;
      branch_taken   = 1'b1;
      branch_target  = 32'h0000_2000;
      jump           = 1'b1;
      Jump_Offset_in = 26'h3FF_FFFF;
      tick();
      branch_taken = 1'b0;
      jump         = 1'b0;
      wait_req("t4b_req_seen");
      chk("t4b_branch_wins", imem_addr, 32'h0000_2000);

      // PC wrap at the top of the address space
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      wait_valid("t5_valid_seen");
      chk("t5_word", Instruction_out, 32'hECA8_6423);
      chk("t5_pcout", PC_Counter_out, 32'h0);
      chk1("t5_req", imem_req, 1'b1);
      chk("t5_addr", imem_addr, 32'h0);

      // reset while a 4-cycle request is pending; its response lands on the IDLE edge
      mem_lat = 4;
      tick();
      reset_in = 1'b0;
      #1;
      chk1("t6_valid", if_valid, 1'b0);
      chk("t6_instr", Instruction_out, NOP);
      chk("t6_pcout", PC_Counter_out, 32'h0);
      chk1("t6_req", imem_req, 1'b0);
      repeat (2) tick();
      reset_in = 1'b1;
      tick();
      chk1("t6_first_req", imem_req, 1'b1);
      chk("t6_first_addr", imem_addr, RST_PC);
      chk1("t6_stray_ignored", if_valid, 1'b0);
      wait_valid("t6_valid_seen");
      chk("t6_word", Instruction_out, 32'h8210_0000);
      chk("t6_pcout_after", PC_Counter_out, 32'h4);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
